// File: rtl/panel_collector_if.sv
// Bundles the panel-snapshot link and host-side frame signals of panel_collector.
// The master drives start and the serializer beat; the slave (collector) drives everything else.
`timescale 1ns/1ps
interface panel_collector_if;
  localparam int unsigned BEAT_W = 5;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned SEG_W  = 64;
  localparam int unsigned LED_W  = 16;

  logic              start;
  logic [BEAT_W-1:0] data_in;
  logic [IDX_W-1:0]  s_in;
  logic              link_clk;
  logic              busy;
  logic [SEG_W-1:0]  seg_out;
  logic [LED_W-1:0]  led_out;
  logic              frame_valid;
  logic              seq_err;

  modport master (
    output start, data_in, s_in,
    input  link_clk, busy, seg_out, led_out, frame_valid, seq_err
  );

  modport slave (
    input  start, data_in, s_in,
    output link_clk, busy, seg_out, led_out, frame_valid, seq_err
  );
endinterface

// File: rtl/panel_collector.sv
// Collector end of the panel-snapshot link: drives link_clk, reassembles 16 beats into seg/led frames.
// Optional beat-index checking is enabled by defining PANEL_SEQ_CHECK_EN.
`timescale 1ns/1ps
module panel_collector #(
  parameter int unsigned HALF_PERIOD = 50,
  parameter int unsigned IDLE_GAP    = 10_000_100,
  parameter int unsigned GAP_W       = 24
) (
  input  logic             clk_100mhz,
  input  logic             rst_n,
  panel_collector_if.slave bus
);

  localparam int unsigned SEG_W  = 64;
  localparam int unsigned LED_W  = 16;
  localparam int unsigned BEAT_N = 4;
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(IDLE_GAP - 1);
  localparam logic [GAP_W-1:0]  HALF_LOAD = GAP_W'(HALF_PERIOD - 1);
  localparam logic [BEAT_N-1:0] LAST_BEAT = BEAT_N'(15);

  // Elaboration-time parameter sanity
  if (HALF_PERIOD < 4) begin : g_half_chk
    $error("panel_collector: HALF_PERIOD must be >= 4");
  end
  if (GAP_W < 32 && IDLE_GAP >= (32'd1 << GAP_W)) begin : g_gap_chk
    $error("panel_collector: GAP_W too narrow for IDLE_GAP");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_CAP_HI,
    S_CAP_LO,
    S_SH_HI,
    S_SH_LO,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [GAP_W-1:0]    phase_q, phase_d;
  logic [BEAT_N-1:0]   beat_q, beat_d;
  logic [SEG_W-1:0]    seg_sh_q, seg_sh_d;
  logic [LED_W-1:0]    led_sh_q, led_sh_d;
  logic [SEG_W-1:0]    seg_out_q, seg_out_d;
  logic [LED_W-1:0]    led_out_q, led_out_d;
  logic                link_clk_q, link_clk_d;
  logic                busy_q, busy_d;
  logic                fv_q, fv_d;
  logic                seq_err_q, seq_err_d;
  logic                phase_tc;

  assign phase_tc = (phase_q == '0);

  // State, counters, shadow and output registers
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      beat_q     <= '0;
      seg_sh_q   <= '0;
      led_sh_q   <= '0;
      seg_out_q  <= '0;
      led_out_q  <= '0;
      link_clk_q <= 1'b0;
      busy_q     <= 1'b0;
      fv_q       <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      beat_q     <= beat_d;
      seg_sh_q   <= seg_sh_d;
      led_sh_q   <= led_sh_d;
      seg_out_q  <= seg_out_d;
      led_out_q  <= led_out_d;
      link_clk_q <= link_clk_d;
      busy_q     <= busy_d;
      fv_q       <= fv_d;
      seq_err_q  <= seq_err_d;
    end
  end

  // Next-state and next-output logic; link_clk follows the state being entered
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_tc ? '0 : phase_q - GAP_W'(1);
    beat_d     = beat_q;
    seg_sh_d   = seg_sh_q;
    led_sh_d   = led_sh_q;
    seg_out_d  = seg_out_q;
    led_out_d  = led_out_q;
    link_clk_d = link_clk_q;
    busy_d     = busy_q;
    fv_d       = 1'b0;
    seq_err_d  = seq_err_q;

    case (state_q)
      S_IDLE: begin
        link_clk_d = 1'b0;
        // A start landing on the frame_valid cycle belongs to the finished frame; drop it
        if (bus.start && !fv_q) begin
          state_d   = S_GAP;
          phase_d   = GAP_LOAD;
          beat_d    = '0;
          busy_d    = 1'b1;
          seq_err_d = 1'b0;
        end
      end

      S_GAP: begin
        if (phase_tc) begin
          state_d    = S_CAP_HI;
          phase_d    = HALF_LOAD;
          link_clk_d = 1'b1;
        end
      end

      S_CAP_HI: begin
        if (phase_tc) begin
          state_d    = S_CAP_LO;
          phase_d    = HALF_LOAD;
          link_clk_d = 1'b0;
        end
      end

      S_CAP_LO: begin
        if (phase_tc) begin
          state_d    = S_SH_HI;
          phase_d    = HALF_LOAD;
          link_clk_d = 1'b1;
        end
      end

      S_SH_HI: begin
        if (phase_tc) begin
          // Beat k lands in seg bits [63-4k -: 4]; (~k)*4 is the low bit of that nibble
          seg_sh_d[{~beat_q, 2'b00} +: 4] = bus.data_in[4:1];
          led_sh_d[~beat_q]               = bus.data_in[0];
`ifdef PANEL_SEQ_CHECK_EN
          if (bus.s_in != BEAT_N'(beat_q + BEAT_N'(1))) begin
            seq_err_d = 1'b1;
          end
`endif
          state_d    = S_SH_LO;
          phase_d    = HALF_LOAD;
          link_clk_d = 1'b0;
        end
      end

      S_SH_LO: begin
        if (phase_tc) begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_DONE;
          end else begin
            beat_d     = BEAT_N'(beat_q + BEAT_N'(1));
            state_d    = S_SH_HI;
            phase_d    = HALF_LOAD;
            link_clk_d = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
`ifdef PANEL_SEQ_CHECK_EN
        if (!seq_err_q) begin
          seg_out_d = seg_sh_q;
          led_out_d = led_sh_q;
          fv_d      = 1'b1;
        end
`else
        seg_out_d = seg_sh_q;
        led_out_d = led_sh_q;
        fv_d      = 1'b1;
`endif
      end

      default: begin
        state_d    = S_IDLE;
        link_clk_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase

`ifndef PANEL_SEQ_CHECK_EN
    seq_err_d = 1'b0;
`endif
  end

  assign bus.link_clk    = link_clk_q;
  assign bus.busy        = busy_q;
  assign bus.seg_out     = seg_out_q;
  assign bus.led_out     = led_out_q;
  assign bus.frame_valid = fv_q;
  assign bus.seq_err     = seq_err_q;

endmodule

// File: tb/tb_panel_collector.sv
// Bench for panel_collector: serializer model with 2-flop edge detect, table of frames, reset corner case.
`timescale 1ns/1ps
module tb_panel_collector;

  localparam int HP       = 4;
  localparam int GAP      = 20;
  localparam int T_RISE   = 1 + GAP;
  localparam int T_FRAME  = 1 + GAP + 34 * HP + 1;
  localparam int N_EDGES  = 17;
  localparam int SER_TOUT = 12;
  localparam int NV       = 8;

  logic clk;
  logic rst_n;
  panel_collector_if bus ();

  panel_collector #(.HALF_PERIOD(HP), .IDLE_GAP(GAP), .GAP_W(24)) dut (
    .clk_100mhz(clk),
    .rst_n     (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serializer model: load on first edge after a timeout, then one beat per rising edge
  logic [63:0] load_seg = '0;
  logic [15:0] load_led = '0;
  logic [63:0] snap_seg = '0;
  logic [15:0] snap_led = '0;
  logic        f1 = 1'b0, f2 = 1'b0, f3 = 1'b0;
  int          idle_cnt = 0;
  bit          ser_free = 1'b1;
  int          ser_cnt = 0;
  int          ser_beat = -1;
  logic [4:0]  ser_data = '0;
  logic [3:0]  ser_idx = '0;
  int          corrupt_beat = -1;
  logic [3:0]  corrupt_val = '0;

  always @(posedge clk) begin
    f1 <= bus.link_clk;
    f2 <= f1;
    f3 <= f2;
    if (f2 && !f3) begin
      idle_cnt <= 0;
      if (ser_free) begin
        ser_free <= 1'b0;
        snap_seg <= load_seg;
        snap_led <= load_led;
        ser_cnt  <= 0;
      end else begin
        ser_data <= {snap_seg[63 - 4 * (ser_cnt % 16) -: 4], snap_led[15 - (ser_cnt % 16)]};
        ser_idx  <= 4'((ser_cnt + 1) % 16);
        ser_beat <= ser_cnt;
        ser_cnt  <= ser_cnt + 1;
      end
    end else if (idle_cnt >= SER_TOUT) begin
      ser_free <= 1'b1;
    end else begin
      idle_cnt <= idle_cnt + 1;
    end
  end

  assign bus.data_in = ser_data;
  assign bus.s_in    = (corrupt_beat == ser_beat) ? corrupt_val : ser_idx;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic [63:0] s, input logic [15:0] l, input int cb,
                           input logic [3:0] cv, input int xs0, input int xs1,
                           output int edges, output int first_rise, output int fv_n,
                           output int fv_cycle, output int busy_fall);
    logic prev;
    load_seg     = s;
    load_led     = l;
    corrupt_beat = cb;
    corrupt_val  = cv;
    edges = 0; first_rise = -1; fv_n = 0; fv_cycle = -1; busy_fall = -1;
    prev = bus.link_clk;
    bus.start = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      bus.start = (n == xs0 || n == xs1);
      if (bus.link_clk && !prev) begin
        edges++;
        if (first_rise < 0) first_rise = n;
      end
      prev = bus.link_clk;
      if (bus.frame_valid) begin
        fv_n++;
        fv_cycle = n;
      end
      if (!bus.busy && busy_fall < 0) busy_fall = n;
      if (busy_fall > 0 && n >= busy_fall + 4) break;
    end
    bus.start    = 1'b0;
    corrupt_beat = -1;
  endtask

  typedef struct {
    logic [63:0] seg;
    logic [15:0] led;
    int          cbeat;
    logic [3:0]  cval;
    int          xs0;
    int          xs1;
    logic        exp_fv;
    logic [63:0] exp_seg;
    logic [15:0] exp_led;
    logic        exp_seq;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    logic [63:0] m_seg;
    logic [15:0] m_led;
    int edges, first_rise, fv_n, fv_cycle, busy_fall;
    bit found;
    logic prev;

    // Stimulus table: directed frames first, randomized ones after
    for (int i = 0; i < NV; i++) begin
      vecs[i].seg   = {$urandom, $urandom};
      vecs[i].led   = 16'($urandom);
      vecs[i].cbeat = -1;
      vecs[i].cval  = '0;
      vecs[i].xs0   = -1;
      vecs[i].xs1   = -1;
      if (i >= 4) begin
        if ($urandom_range(0, 1) == 1) begin
          vecs[i].cbeat = int'($urandom_range(0, 15));
          vecs[i].cval  = 4'((vecs[i].cbeat + 2 + int'($urandom_range(0, 14))) % 16);
        end
        vecs[i].xs0 = int'($urandom_range(2, 150));
      end
    end
    vecs[0].seg = 64'h0123_4567_89AB_CDEF;
    vecs[0].led = 16'hA5C3;
    vecs[1].xs0 = 5;
    vecs[1].xs1 = 60;
    vecs[2].cbeat = 5;
    vecs[2].cval  = 4'h3;

    // Reference: a frame publishes unless its index stream was corrupted and checking is on
    m_seg = '0;
    m_led = '0;
    for (int i = 0; i < NV; i++) begin
      vecs[i].exp_fv  = 1'b1;
      vecs[i].exp_seq = 1'b0;
`ifdef PANEL_SEQ_CHECK_EN
      if (vecs[i].cbeat >= 0 && vecs[i].cval != 4'((vecs[i].cbeat + 1) % 16)) begin
        vecs[i].exp_fv  = 1'b0;
        vecs[i].exp_seq = 1'b1;
      end
`endif
      if (vecs[i].exp_fv) begin
        m_seg = vecs[i].seg;
        m_led = vecs[i].led;
      end
      vecs[i].exp_seg = m_seg;
      vecs[i].exp_led = m_led;
    end

    bus.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_link_clk", 64'(bus.link_clk), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_seg_out", bus.seg_out, 64'd0);
    check("rst_led_out", 64'(bus.led_out), 64'd0);
    check("rst_frame_valid", 64'(bus.frame_valid), 64'd0);
    check("rst_seq_err", 64'(bus.seq_err), 64'd0);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      run_frame(vecs[i].seg, vecs[i].led, vecs[i].cbeat, vecs[i].cval, vecs[i].xs0, vecs[i].xs1,
                edges, first_rise, fv_n, fv_cycle, busy_fall);
      check($sformatf("v%0d_edges", i), 64'(edges), 64'(N_EDGES));
      check($sformatf("v%0d_first_rise", i), 64'(first_rise), 64'(T_RISE));
      check($sformatf("v%0d_busy_fall", i), 64'(busy_fall), 64'(T_FRAME));
      check($sformatf("v%0d_fv_count", i), 64'(fv_n), 64'(vecs[i].exp_fv));
      if (vecs[i].exp_fv)
        check($sformatf("v%0d_fv_cycle", i), 64'(fv_cycle), 64'(T_FRAME));
      check($sformatf("v%0d_seg_out", i), bus.seg_out, vecs[i].exp_seg);
      check($sformatf("v%0d_led_out", i), 64'(bus.led_out), 64'(vecs[i].exp_led));
      check($sformatf("v%0d_seq_err", i), 64'(bus.seq_err), 64'(vecs[i].exp_seq));
    end

    // Reset while link_clk is high for beat 7 (9th rising edge)
    load_seg  = {$urandom, $urandom};
    load_led  = 16'($urandom);
    found     = 1'b0;
    edges     = 0;
    prev      = bus.link_clk;
    bus.start = 1'b1;
    for (int n = 1; n <= 300 && !found; n++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.link_clk && !prev) begin
        edges++;
        if (edges == 9) found = 1'b1;
      end
      prev = bus.link_clk;
    end
    check("mid_reach_beat7", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_link_clk", 64'(bus.link_clk), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_seg_out", bus.seg_out, 64'd0);
    check("mid_rst_led_out", 64'(bus.led_out), 64'd0);
    check("mid_rst_frame_valid", 64'(bus.frame_valid), 64'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame(64'hFFFF_0000_FFFF_0000, 16'h00FF, -1, 4'h0, -1, -1,
              edges, first_rise, fv_n, fv_cycle, busy_fall);
    check("post_rst_edges", 64'(edges), 64'(N_EDGES));
    check("post_rst_fv_count", 64'(fv_n), 64'd1);
    check("post_rst_fv_cycle", 64'(fv_cycle), 64'(T_FRAME));
    check("post_rst_seg_out", bus.seg_out, 64'hFFFF_0000_FFFF_0000);
    check("post_rst_led_out", 64'(bus.led_out), 64'h00FF);
    check("post_rst_seq_err", 64'(bus.seq_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/panel_collector.md
Name: panel_collector

Overview:
- Collector end of the panel-snapshot link, running on the board's 100 MHz clock.
- Generates the slow link strobe clock that the panel serializer consumes. The serializer returns 5-bit beats: 4 seven-segment bits plus 1 LED bit, along with a 4-bit beat index.
- Reassembles the beats into a 64-bit seg snapshot and a 16-bit led snapshot and presents them as one frame to the host-side logic.

Parameters:
- HALF_PERIOD, 50, clk_100mhz cycles per high phase and per low phase of link_clk; must be >= 4.
- IDLE_GAP, 10_000_100, low-time cycles before each frame; must exceed the serializer's 10_000_000-cycle busy timeout.
- GAP_W, 24, width of the gap/phase counter; must satisfy 2^GAP_W > IDLE_GAP.

Ports:
- clk_100mhz  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request for a frame; ignored unless idle.
- data_in  in  5  serializer beat, {seg nibble[3:0], led bit}.
- s_in  in  4  serializer beat index.
- link_clk  out  1  strobe clock to the serializer.
- busy  out  1  high from accepted start until frame_valid/abort.
- seg_out  out  64  last complete seg snapshot.
- led_out  out  16  last complete led snapshot.
- frame_valid  out  1  one-cycle pulse when seg_out/led_out update.
- seq_err  out  1  sticky beat-index mismatch flag; cleared by next accepted start.

Behaviour:
- Decided interface rule: one clock, clk_100mhz; reset rst_n is asynchronous, active-low.
- Reset values: link_clk=0, busy=0, seg_out=0, led_out=0, frame_valid=0, seq_err=0. FSM enters IDLE and all counters clear.
- FSM states and transitions:
  - IDLE: wait for start; start sets busy=1 and clears seq_err.
  - GAP: link_clk=0 for IDLE_GAP cycles. This lets the serializer time out to free so the next edge loads a fresh snapshot.
  - CAP_HI, CAP_LO: link_clk=1 then 0, each for HALF_PERIOD cycles. This is the load edge; no sampling.
  - SH_HI, SH_LO: beat k = 0..15; link_clk=1 for HALF_PERIOD, then 0 for HALF_PERIOD.
  - Sampling point: on the last cycle of SH_HI (HALF_PERIOD-1 cycles after the rising edge), sample data_in and s_in. This covers the serializer's 2-flop edge detect plus output register (3 cycles).
  - Beat k placement: data_in[4:1] goes into shadow seg[63-4k -: 4]; data_in[0] goes into shadow led[15-k].
  - Expected s_in for beat k is (k+1) mod 16; beat 15 expects 0, as the 4-bit index wraps.
  - After SH_LO of beat 15, go to DONE.
  - DONE: copy shadow to seg_out/led_out, pulse frame_valid for 1 cycle, clear busy, return to IDLE.
- Latency:
  - start to first rising edge of link_clk: 1 + IDLE_GAP cycles.
  - Full frame: 1 + IDLE_GAP + 34*HALF_PERIOD + 1 cycles.
- Output holding: seg_out/led_out change only on frame_valid. They hold the previous frame during collection.
- Edge cases:
  - start while busy: ignored.
  - start in the same cycle as frame_valid: ignored; FSM leaves DONE for IDLE first.
  - Reset mid-frame: immediate return to IDLE with link_clk=0. Shadow registers and outputs clear; no frame_valid.
- Counter rules:
  - Phase counter counts down from its load value to 0; the terminal-count cycle is the state's last cycle.
  - Beat counter is 4 bits; wrap from 15 exits the loop and does not re-enter it.

Optional Feature:
- Macro: PANEL_SEQ_CHECK_EN.
- Defined:
  - Each sampled s_in is compared to its expected value.
  - Any mismatch sets seq_err (sticky). At DONE, frame_valid is suppressed and seg_out/led_out are not updated; busy still clears.
- Undefined:
  - s_in is ignored and seq_err is tied 0.
  - Every completed frame updates the outputs and pulses frame_valid.

Test Plan (HALF_PERIOD=4, IDLE_GAP=20, bench serializer model with 2-flop edge detect):
- Snapshot load: model loaded seg=64'h0123_4567_89AB_CDEF, led=16'hA5C3; pulse start -> exactly 17 rising edges on link_clk. Then frame_valid pulses once with seg_out=64'h0123_4567_89AB_CDEF and led_out=16'hA5C3, busy falls the same cycle, seq_err=0.
- Timing: check first rising edge of link_clk at cycle 21 after start, and frame_valid at cycle 1+20+136+1=158 after start.
- Busy start: pulse start at cycles 5 and 60 of a frame -> no extra edges; single frame_valid.
- Reset mid-frame: drop rst_n during beat 7 -> link_clk=0, busy=0, seg_out=0 immediately. The next start yields a correct full frame with seg=64'hFFFF_0000_FFFF_0000, led=16'h00FF.
- Sequence check (PANEL_SEQ_CHECK_EN defined): force s_in=4'h3 at beat 5 -> seq_err=1, no frame_valid, outputs keep prior frame. The next start clears seq_err and a clean frame updates the outputs.
- Sequence check disabled (PANEL_SEQ_CHECK_EN undefined): same corrupted s_in -> seq_err stays 0, frame_valid pulses, data correct.
